stoch_decode: RTL and testbench

STOCH_DECODE -- requirements
Module: stoch_decode

---
 rtl/stoch_decode.sv | 99 +++++++++
 tb/tb_stoch_decode.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/stoch_decode.sv
// stoch_decode: windowed stochastic-bitstream decoder.
//
// Counts the signed sum of (x_pos - x_neg) over WINDOW_LEN consecutive
// samples. The first sample is taken on the same edge that accepts start,
// so a window consumes exactly WINDOW_LEN samples. After the last sample
// the sum is loaded into y and valid pulses for one cycle.
//
// Ports
//   CLK    in   sole clock, rising edge
//   nRST   in   asynchronous active-low reset
//   start  in   begin a window (sampled only in IDLE)
//   x_pos  in   positive-channel stochastic bit
//   x_neg  in   negative-channel stochastic bit
//   busy   out  high while a window is being accumulated
//   valid  out  one-cycle pulse: new result on y
//   y      out  signed window sum, held until the next window completes
module stoch_decode #(
  parameter  int WINDOW_LEN = 256,
  localparam int OUT_WIDTH  = $clog2(WINDOW_LEN + 1) + 1,
  localparam int CNT_WIDTH  = $clog2(WINDOW_LEN)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        start,
  input  logic                        x_pos,
  input  logic                        x_neg,
  output logic                        busy,
  output logic                        valid,
  output logic signed [OUT_WIDTH-1:0] y
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WINDOW_LEN - 1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic signed [OUT_WIDTH-1:0] acc;
  logic signed [OUT_WIDTH-1:0] step;
  logic        [CNT_WIDTH-1:0] idx;
  logic                        last;

  // Per-sample contribution: +1 for (1,0), -1 for (0,1), 0 otherwise.
  always_comb begin
    step = '0;
    if (x_pos && !x_neg)
      step = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
    else if (!x_pos && x_neg)
      step = '1;
  end

  assign last = (idx == LAST_IDX);
  assign busy = (state == ACCUM);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. The start edge already consumes sample 0, so ACCUM begins
  // at index 1 and the terminal edge is the one taking index WINDOW_LEN-1.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc   <= '0;
      idx   <= '0;
      y     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc <= step;
            idx <= CNT_WIDTH'(1);
          end
        end
        ACCUM: begin
          acc <= acc + step;
          idx <= idx + CNT_WIDTH'(1);
          if (last) begin
            y     <= acc + step;
            valid <= 1'b1;
            idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_decode.sv
// Self-checking bench for stoch_decode with WINDOW_LEN = 8.
// The reference is a plain integer sum of (x_pos - x_neg) over the bits the
// bench itself drives during each window.
module tb_stoch_decode;

  localparam int WL = 8;
  localparam int OW = $clog2(WL + 1) + 1;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic                 start;
  logic                 x_pos;
  logic                 x_neg;
  logic                 busy;
  logic                 valid;
  logic signed [OW-1:0] y;

  int checks = 0;
  int errors = 0;

  stoch_decode #(.WINDOW_LEN(WL)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .start (start),
    .x_pos (x_pos),
    .x_neg (x_neg),
    .busy  (busy),
    .valid (valid),
    .y     (y)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit before sampling outputs.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full window: bits xp[i]/xn[i] are sample i, start rides with sample 0.
  // glitch_at >= 1 raises start on that ACCUM sample (must be ignored).
  task automatic window(input string tag, input logic [WL-1:0] xp,
                        input logic [WL-1:0] xn, input int glitch_at);
    int exp_sum = 0;
    for (int i = 0; i < WL; i++)
      exp_sum += int'(xp[i]) - int'(xn[i]);
    for (int i = 0; i < WL; i++) begin
      start = (i == 0) || (i == glitch_at);
      x_pos = xp[i];
      x_neg = xn[i];
      tick();
      if (i < WL - 1) begin
        chk({tag, ".busy"}, int'(busy), 1);
        chk({tag, ".valid_early"}, int'(valid), 0);
      end
    end
    start = 1'b0;
    chk({tag, ".valid"}, int'(valid), 1);
    chk({tag, ".busy_end"}, int'(busy), 0);
    chk({tag, ".y"}, int'(y), exp_sum);
    x_pos = $urandom_range(0, 1);
    x_neg = $urandom_range(0, 1);
    tick();
    chk({tag, ".valid_drop"}, int'(valid), 0);
    chk({tag, ".busy_idle"}, int'(busy), 0);
    chk({tag, ".y_hold"}, int'(y), exp_sum);
  endtask

  initial begin
    logic [WL-1:0] rp, rn;
    int            sum;

    nRST  = 1'b0;
    start = 1'b0;
    x_pos = 1'b0;
    x_neg = 1'b0;
    #2;
    chk("rst.busy", int'(busy), 0);
    chk("rst.valid", int'(valid), 0);
    chk("rst.y", int'(y), 0);
    #10 nRST = 1'b1;

    // Idle with start low: nothing happens even with active inputs.
    x_pos = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle.busy", int'(busy), 0);
      chk("idle.valid", int'(valid), 0);
    end

    window("allpos", 8'hFF, 8'h00, -1);
    window("allneg", 8'h00, 8'hFF, -1);
    window("both", 8'hFF, 8'hFF, -1);
    window("alt", 8'b0101_0101, 8'h00, -1);

    for (int r = 0; r < 4; r++) begin
      rp = WL'($urandom);
      rn = WL'($urandom);
      window($sformatf("rand%0d", r), rp, rn, -1);
    end

    rp = WL'($urandom);
    rn = WL'($urandom);
    window("glitch", rp, rn, 3);

    // start held high: back-to-back windows, a result every WL cycles.
    start = 1'b1;
    for (int w = 0; w < 3; w++) begin
      sum = 0;
      for (int i = 0; i < WL; i++) begin
        x_pos = $urandom_range(0, 1);
        x_neg = $urandom_range(0, 1);
        sum += int'(x_pos) - int'(x_neg);
        tick();
        if (i < WL - 1) chk("b2b.valid_early", int'(valid), 0);
      end
      chk($sformatf("b2b%0d.valid", w), int'(valid), 1);
      chk($sformatf("b2b%0d.y", w), int'(y), sum);
    end
    start = 1'b0;
    tick();
    chk("b2b.valid_drop", int'(valid), 0);

    // Reset between edges after five samples of a window.
    start = 1'b1;
    x_pos = 1'b1;
    x_neg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
    end
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst.busy", int'(busy), 0);
    chk("mid_rst.valid", int'(valid), 0);
    chk("mid_rst.y", int'(y), 0);
    tick();
    #2 nRST = 1'b1;
    for (int i = 0; i < WL + 2; i++) begin
      tick();
      chk("post_rst.valid", int'(valid), 0);
      chk("post_rst.busy", int'(busy), 0);
    end

    rp = WL'($urandom);
    rn = WL'($urandom);
    window("after_rst", rp, rn, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
